// File: rtl/systolic_scheduler.sv
// systolic_scheduler
// Sequencing controller for an N x N systolic MAC array. A job clears the
// accumulators, streams skewed per-lane k indices to the A/B operand buffers,
// keeps the array enabled through the drain window, then pulses done.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; abandons any job
//   start        job request, sampled only in IDLE
//   k_len        inner dimension, latched when start is accepted
//   busy         high whenever not IDLE
//   done         one-cycle pulse once every PE holds its final result
//   array_clear  one-cycle accumulator clear at the start of a job
//   array_enable PE enable covering the fetch and drain window
//   lane_valid   bit i: lane i fetches a real operand this cycle
//   lane_k       lane i fetch index in bits [i*KW +: KW]
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one cycle, zero the accumulators
// FETCH | skewed operand fetch, k_len + 2(N-1) cycles
// DRAIN | DRAIN_CYCLES cycles for in-flight operands to accumulate
// DONE  | one cycle, results are final
module systolic_scheduler #(
  parameter int N            = 4,
  parameter int K_MAX        = 255,
  parameter int KW           = $clog2(K_MAX + 1),
  parameter int DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            array_clear,
  output logic            array_enable,
  output logic [N-1:0]    lane_valid,
  output logic [N*KW-1:0] lane_k
);

  // Fetch counter must reach K_MAX + 2(N-1) - 1 without wrapping.
  localparam int FW         = $clog2(K_MAX + 2*(N-1) + 1);
  localparam int DW         = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam logic [FW-1:0] SKEW = FW'(2*(N-1));

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t          state, next_state;
  logic [KW-1:0]   k_len_q;
  logic [FW-1:0]   t;
  logic [DW-1:0]   drain_cnt;
  logic            enable_d, enable_q;
  logic            fetch_last;

  assign fetch_last   = (t == FW'(k_len_q) + SKEW - FW'(1));
  assign array_enable = enable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k_len_q   <= '0;
      t         <= '0;
      drain_cnt <= '0;
      enable_q  <= 1'b0;
    end else begin
      state    <= next_state;
      enable_q <= enable_d;
      if (state == IDLE && start)
        k_len_q <= k_len;
      if (state == FETCH)
        t <= t + FW'(1);
      else
        t <= '0;
      // Down-counter preloaded outside DRAIN; terminal count is zero.
      if (state == DRAIN)
        drain_cnt <= drain_cnt - DW'(1);
      else
        drain_cnt <= DW'(DRAIN_LOAD);
    end
  end

  always_comb begin
    next_state  = state;
    busy        = (state != IDLE);
    done        = (state == DONE);
    array_clear = (state == CLEAR);
    lane_valid  = '0;
    lane_k      = '0;

    unique case (state)
      IDLE:  if (start) next_state = CLEAR;
      CLEAR: next_state = (k_len_q != '0) ? FETCH : DONE;
      FETCH: if (fetch_last) next_state = (DRAIN_CYCLES > 0) ? DRAIN : DONE;
      DRAIN: if (drain_cnt == '0) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Enable is the registered window, but it is dropped on the edge into
    // DONE so the PEs are never enabled while done is reported.
    enable_d = (state == FETCH || state == DRAIN) &&
               (next_state == FETCH || next_state == DRAIN);

    // Lane i lags lane 0 by i cycles; it is valid for k_len cycles.
    if (state == FETCH) begin
      for (int i = 0; i < N; i++) begin
        if (t >= FW'(i) && (t - FW'(i)) < FW'(k_len_q)) begin
          lane_valid[i]        = 1'b1;
          lane_k[i*KW +: KW]   = KW'(t - FW'(i));
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_scheduler.sv
module tb_systolic_scheduler;

  localparam int N     = 4;
  localparam int K_MAX = 255;
  localparam int KW    = 8;
  localparam int DRAIN = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            busy, done, array_clear, array_enable;
  logic [N-1:0]    lane_valid;
  logic [N*KW-1:0] lane_k;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  systolic_scheduler #(.N(N), .K_MAX(K_MAX), .KW(KW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .array_clear(array_clear),
    .array_enable(array_enable), .lane_valid(lane_valid), .lane_k(lane_k)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Job model: position of the current job in cycles since start acceptance.
  bit m_active = 0;
  int m_c = 0;
  int m_k = 0;
  int m_done_c = 0;

  always @(posedge clk) begin
    if (reset) m_active = 0;
    else if (m_active) begin
      if (m_c >= m_done_c) m_active = 0;
      else m_c++;
    end else if (start) begin
      m_active = 1;
      m_c = 1;
      m_k = int'(k_len);
      m_done_c = (m_k > 0) ? 2 + m_k + 2*(N-1) + DRAIN : 2;
    end
  end

  int e_busy, e_done, e_clear, e_en, e_t;
  logic [N-1:0]    e_valid;
  logic [N*KW-1:0] e_k;

  always @(negedge clk) begin
    if (chk_en) begin
      e_busy = 0; e_done = 0; e_clear = 0; e_en = 0;
      e_valid = '0; e_k = '0;
      if (m_active) begin
        e_busy  = 1;
        e_clear = (m_c == 1);
        e_done  = (m_c == m_done_c);
        e_en    = (m_k > 0 && m_c >= 3 && m_c <= m_done_c - 1);
        if (m_k > 0 && m_c >= 2 && m_c <= 1 + m_k + 2*(N-1)) begin
          e_t = m_c - 2;
          for (int i = 0; i < N; i++)
            if (e_t >= i && e_t - i < m_k) begin
              e_valid[i] = 1'b1;
              e_k[i*KW +: KW] = KW'(e_t - i);
            end
        end
      end
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      chk("array_clear", int'(array_clear), e_clear);
      chk("array_enable", int'(array_enable), e_en);
      chk("lane_valid", int'(lane_valid), int'(e_valid));
      chk("lane_k", int'(lane_k), int'(e_k));
    end
  end

  int o_clear, o_done, o_done_cnt, o_busy_low, o_en_first, o_en_last, o_any;
  int o_l0_first, o_l0_last, o_l0_k3, o_l3_first, o_l3_last, o_l3_klast, o_post_rst;

  // Called #1 after a rising edge with the DUT idle. Cycle c of the loop is
  // the c-th cycle after the acceptance edge.
  task automatic run_job(input int k, input int inj_cyc, input int inj_kind, input int max_cyc);
    o_clear = -1; o_done = -1; o_done_cnt = 0; o_busy_low = -1;
    o_en_first = -1; o_en_last = -1; o_any = 0;
    o_l0_first = -1; o_l0_last = -1; o_l0_k3 = -1;
    o_l3_first = -1; o_l3_last = -1; o_l3_klast = -1; o_post_rst = -1;
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c == inj_cyc) begin
        if (inj_kind == 1) begin start = 1'b1; k_len = KW'(7); end
        else if (inj_kind == 2) reset = 1'b1;
      end
      @(negedge clk);
      if (array_clear && o_clear < 0) o_clear = c;
      if (done) begin o_done_cnt++; if (o_done < 0) o_done = c; end
      if (o_done >= 0 && c == o_done + 1 && !busy) o_busy_low = c;
      if (array_enable) begin if (o_en_first < 0) o_en_first = c; o_en_last = c; end
      if (lane_valid != '0) o_any = 1;
      if (lane_valid[0]) begin
        if (o_l0_first < 0) o_l0_first = c;
        o_l0_last = c;
        if (c == 3) o_l0_k3 = int'(lane_k[KW-1:0]);
      end
      if (lane_valid[3]) begin
        if (o_l3_first < 0) o_l3_first = c;
        o_l3_last = c;
        o_l3_klast = int'(lane_k[3*KW +: KW]);
      end
      if (inj_kind == 2 && c == inj_cyc + 1)
        o_post_rst = int'({busy, done, array_clear, array_enable, lane_valid}) | int'(lane_k);
      @(posedge clk); #1;
      start = 1'b0;
      reset = 1'b0;
      if (o_busy_low >= 0) break;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_outputs",
          int'({busy, done, array_clear, array_enable, lane_valid}) | int'(lane_k), 0);
    end
    @(posedge clk); #1;

    run_job(3, 0, 0, 30);
    chk("k3_clear_cyc", o_clear, 1);
    chk("k3_lane0_first", o_l0_first, 2);
    chk("k3_lane0_last", o_l0_last, 4);
    chk("k3_lane0_k_at3", o_l0_k3, 1);
    chk("k3_lane3_first", o_l3_first, 5);
    chk("k3_lane3_last", o_l3_last, 7);
    chk("k3_lane3_klast", o_l3_klast, 2);
    chk("k3_en_first", o_en_first, 3);
    chk("k3_en_last", o_en_last, 13);
    chk("k3_done_cyc", o_done, 14);
    chk("k3_done_count", o_done_cnt, 1);
    chk("k3_busy_low", o_busy_low, 15);

    run_job(0, 0, 0, 10);
    chk("k0_clear_cyc", o_clear, 1);
    chk("k0_done_cyc", o_done, 2);
    chk("k0_any_valid", o_any, 0);
    chk("k0_en_first", o_en_first, -1);

    run_job(3, 6, 1, 30);
    chk("ign_done_cyc", o_done, 14);
    chk("ign_done_count", o_done_cnt, 1);
    chk("ign_en_last", o_en_last, 13);
    chk("ign_lane3_last", o_l3_last, 7);

    run_job(3, 12, 2, 18);
    chk("rst_done_count", o_done_cnt, 0);
    chk("rst_idle_outputs", o_post_rst, 0);

    run_job(1, 0, 0, 30);
    chk("k1_done_cyc", o_done, 12);
    chk("k1_busy_low", o_busy_low, 13);

    run_job(255, 0, 0, 300);
    chk("kmax_lane3_last_cyc", o_l3_last, 259);
    chk("kmax_lane3_klast", o_l3_klast, 254);
    chk("kmax_lane0_last_cyc", o_l0_last, 256);
    chk("kmax_done_cyc", o_done, 266);
    chk("kmax_done_count", o_done_cnt, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
